// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for uart_tx_fifo.
//   tx_valid   : producer offers tx_data
//   tx_data    : word to send, LSB first on the line
//   tx_ready   : FIFO has room; word taken on tx_valid & tx_ready at clk edge
//   fifo_count : words queued, not counting the frame in flight
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic [CNT_W-1:0]     fifo_count;

    modport master (output tx_valid, tx_data, input tx_ready, fifo_count);
    modport slave  (input tx_valid, tx_data, output tx_ready, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised RS-232 transmitter with a small input FIFO.
//   clk, rst_n : system clock (rising edge), async active-low reset
//   bus        : valid/ready push port plus fifo_count (uart_tx_fifo_if.slave)
//   TxD        : registered serial line, idle high
//   TxD_busy   : frame in flight or words still queued
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD          = 460800,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus,
    output logic          TxD,
    output logic          TxD_busy
);
    localparam int BIT_CYCLES = (CLK_FREQUENCY + BAUD / 2) / BAUD;
    localparam int TMR_W      = $clog2(BIT_CYCLES);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

    logic                 push, pop, empty, bit_done;
    logic [DATA_BITS-1:0] head;

    // Push depends only on the registered count: a full FIFO refuses even
    // if a pop happens on the same edge.
    assign push     = bus.tx_valid && (cnt_q != CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign bit_done = (tmr_q == TMR_LAST);

    assign bus.tx_ready   = (cnt_q != CNT_FULL);
    assign bus.fifo_count = cnt_q;
    assign TxD            = txd_q;
    assign TxD_busy       = (state_q != S_IDLE) || !empty;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.tx_data;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // TxD is registered from the current state, so the line trails the FSM by
    // one clock; every bit still lasts exactly BIT_CYCLES clocks.
    always_comb begin
        state_d = state_q;
        tmr_d   = bit_done ? '0 : tmr_q + 1'b1;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = 1'b1;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd_d  = 1'b0;
                idx_d  = '0;
                stop_d = 1'b0;
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                txd_d = shift_q[0];
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                txd_d = par_q;
                if (bit_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop_q == STOP_LAST) begin
                        // Chain straight into the next start bit when work is queued.
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 1);
            tmr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances at 4 clocks/bit with different
// frame formats, a frame scoreboard per instance, and directed checks.
module tb_uart_tx_fifo;
    localparam int NDUT = 4;
    localparam int BC   = 4;
    localparam int TCLK = 10;
    localparam int DBS[NDUT] = '{8, 8, 8, 7};
    localparam int PAR[NDUT] = '{0, 2, 1, 1};
    localparam int STP[NDUT] = '{1, 2, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drv_vld [NDUT];
    logic [8:0] drv_data[NDUT];
    logic       rdy [NDUT];
    logic       txd [NDUT];
    logic       busy[NDUT];
    logic [2:0] cnt [NDUT];
    int         n_chk = 0, n_err = 0;
    int         n_exp[NDUT];
    int         n_got[NDUT];
    int         a_starts[$];

    always #(TCLK / 2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : gd
        localparam int DB = DBS[g];
        localparam int PM = PAR[g];
        localparam int SB = STP[g];
        localparam int FL = 1 + DB + ((PM != 0) ? 1 : 0) + SB;

        uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(4)) ifc ();
        assign ifc.tx_valid = drv_vld[g];
        assign ifc.tx_data  = drv_data[g][DB-1:0];
        assign rdy[g]       = ifc.tx_ready;
        assign cnt[g]       = ifc.fifo_count;

        uart_tx_fifo #(
            .CLK_FREQUENCY(4), .BAUD(1), .DATA_BITS(DB),
            .PARITY(PM), .STOP_BITS(SB), .FIFO_DEPTH(4)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(ifc), .TxD(txd[g]), .TxD_busy(busy[g])
        );

        logic [15:0] exp_q[$];
        logic        abort;

        // Expected line bits, LSB = first bit on the wire.
        function automatic logic [15:0] mk_frame(input logic [8:0] d);
            logic [15:0] f;
            logic        p;
            f    = '1;
            f[0] = 1'b0;
            p    = (PM == 1);
            for (int i = 0; i < DB; i++) begin
                f[1 + i] = d[i];
                p        = p ^ d[i];
            end
            if (PM != 0) f[1 + DB] = p;
            return f;
        endfunction

        always @(posedge clk) begin
            if (rst_n && drv_vld[g] && rdy[g]) begin
                exp_q.push_back(mk_frame(drv_data[g]));
                n_exp[g]++;
            end
        end

        always @(negedge rst_n) begin
            exp_q.delete();
            abort = 1'b1;
        end

        initial begin : mon
            logic [15:0] bits;
            forever begin
                @(negedge txd[g]);
                if (rst_n) begin
                    abort = 1'b0;
                    if (g == 0) a_starts.push_back(int'($time));
                    bits = '1;
                    for (int b = 0; b < FL; b++) begin
                        repeat ((b == 0) ? BC / 2 : BC) @(negedge clk);
                        bits[b] = txd[g];
                    end
                    if (!abort) begin
                        chk($sformatf("sb_nonempty%0d", g), exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            chk($sformatf("frame%0d", g), bits, exp_q.pop_front());
                            n_got[g]++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [8:0] v, input int budget);
        int   n;
        logic ok;
        n = 0;
        drv_data[d] = v;
        drv_vld[d]  = 1'b1;
        do begin
            ok = rdy[d];
            @(negedge clk);
            n++;
        end while (!ok && n < budget);
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy[0] | busy[1] | busy[2] | busy[3]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", n < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] f1;
        int         ns;
        for (int i = 0; i < NDUT; i++) begin
            drv_vld[i] = 1'b0; drv_data[i] = '0; n_exp[i] = 0; n_got[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("in_rst_txd", txd[0], 1);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_txd", txd[i], 1);
            chk("rst_rdy", rdy[i], 1);
            chk("rst_cnt", cnt[i], 0);
            chk("rst_busy", busy[i], 0);
        end

        // 8N1, 0x55: exact per-clock waveform and latency.
        f1 = {1'b1, 8'h55, 1'b0};
        drv_data[0] = 9'h055; drv_vld[0] = 1'b1;
        @(negedge clk);
        drv_vld[0] = 1'b0; drv_data[0] = 9'h1AA;
        chk("t1_cnt_push", cnt[0], 1);
        @(negedge clk);
        chk("t1_txd_n1", txd[0], 1);
        chk("t1_cnt_pop", cnt[0], 0);
        chk("t1_busy", busy[0], 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("t1_bit%0d", c), txd[0], f1[c / 4]);
            if (c == 38) chk("t1_busy_stop", busy[0], 1);
            if (c == 39) chk("t1_busy_end", busy[0], 0);
        end

        // Parity/width variants in parallel.
        drv_data[1] = 9'h0A5; drv_data[2] = 9'h0A5; drv_data[3] = 9'h07F;
        drv_vld[1] = 1'b1; drv_vld[2] = 1'b1; drv_vld[3] = 1'b1;
        @(negedge clk);
        drv_vld[1] = 1'b0; drv_vld[2] = 1'b0; drv_vld[3] = 1'b0;
        wait_idle(200);

        // Burst of five, then a held word against a full FIFO.
        for (int v = 1; v <= 5; v++) send(0, 9'(v), 5);
        drv_data[0] = 9'h0EE;
        chk("t4_cnt_full", cnt[0], 4);
        chk("t4_rdy_full", rdy[0], 0);
        repeat (10) begin
            @(negedge clk);
            chk("t5_cnt_hold", cnt[0], 4);
            chk("t5_rdy_hold", rdy[0], 0);
        end
        send(0, 9'h0EE, 100);
        drv_vld[0] = 1'b0;
        wait_idle(400);
        chk("t4_cnt_drain", cnt[0], 0);
        chk("t4_starts", a_starts.size(), 7);
        if (a_starts.size() == 7)
            for (int i = 1; i < 6; i++)
                chk("t4_no_gap", a_starts[i + 1] - a_starts[i], 10 * BC * TCLK);
        @(negedge clk);
        chk("n_exp0", n_exp[0], 7);
        for (int i = 0; i < NDUT; i++) chk("sb_drained", n_got[i], n_exp[i]);

        // Reset in the middle of data bit 3 with two words queued.
        ns = a_starts.size();
        send(0, 9'h011, 5);
        send(0, 9'h022, 5);
        send(0, 9'h033, 5);
        drv_vld[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("t6_started", a_starts.size(), ns + 1);
        chk("t6_pre_txd", txd[0], 0);
        chk("t6_pre_cnt", cnt[0], 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_txd", txd[0], 1);
        chk("t6_rst_cnt", cnt[0], 0);
        chk("t6_rst_busy", busy[0], 0);
        chk("t6_rst_rdy", rdy[0], 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("t6_quiet_txd", txd[0], 1);
        end
        chk("t6_quiet_busy", busy[0], 0);
        chk("t6_no_frame", a_starts.size(), ns + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
